// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared selects and channel depth for stream_demux_2 (macro STREAM_DEMUX_2_SKID_EN)
package demux_pkg;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

`ifdef STREAM_DEMUX_2_SKID_EN
  localparam int CHAN_DEPTH = 2;
`else
  localparam int CHAN_DEPTH = 1;
`endif

endpackage

// File: rtl/stream_demux_2_chan.sv
// rtl/stream_demux_2_chan.sv - one output channel buffer of stream_demux_2 (macro STREAM_DEMUX_2_SKID_EN)
module stream_demux_2_chan
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             can_accept,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic pop;

  assign pop = out_valid & out_ready;

`ifdef STREAM_DEMUX_2_SKID_EN

  // Two-entry ring: 1-bit pointers wrap naturally.
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // Ready comes from registered occupancy only, so no ready-to-ready path.
  assign can_accept = (count < 2'(CHAN_DEPTH));
  assign out_valid  = (count != 2'd0);
  assign out_data   = mem[rd_ptr];

  // Ring storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`else

  // Single holding register; a full slot may refill in the cycle it drains.
  logic [WIDTH-1:0] data_q;
  logic             full_q;

  assign can_accept = ~full_q | out_ready;
  assign out_valid  = full_q;
  assign out_data   = data_q;

  // Holding register and occupancy flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        data_q <= push_data;
      end
      if (push) begin
        full_q <= 1'b1;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: rtl/stream_demux_2.sv
// rtl/stream_demux_2.sv - 1-to-2 registered stream demultiplexer (macro STREAM_DEMUX_2_SKID_EN)
module stream_demux_2
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
);

  logic can_accept1;
  logic can_accept2;
  logic push1;
  logic push2;
  logic in_xfer;

  // Ready looks only at the addressed channel, so a stalled channel never blocks the other.
  assign in_ready = ~rst & ((in_sel == SEL_OUT2) ? can_accept2 : can_accept1);
  assign in_xfer  = in_valid & in_ready;
  assign push1    = in_xfer & (in_sel == SEL_OUT1);
  assign push2    = in_xfer & (in_sel == SEL_OUT2);

  stream_demux_2_chan #(.WIDTH(WIDTH)) u_chan1 (
    .clk        (clk),
    .rst        (rst),
    .push       (push1),
    .push_data  (in_data),
    .can_accept (can_accept1),
    .out_data   (out1_data),
    .out_valid  (out1_valid),
    .out_ready  (out1_ready)
  );

  stream_demux_2_chan #(.WIDTH(WIDTH)) u_chan2 (
    .clk        (clk),
    .rst        (rst),
    .push       (push2),
    .push_data  (in_data),
    .can_accept (can_accept2),
    .out_data   (out2_data),
    .out_valid  (out2_valid),
    .out_ready  (out2_ready)
  );

endmodule

// File: tb/tb_stream_demux_2.sv
// tb/tb_stream_demux_2.sv - self-checking bench for stream_demux_2 (macro STREAM_DEMUX_2_SKID_EN)
module tb_stream_demux_2;

`ifdef STREAM_DEMUX_2_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
  logic [31:0] out2_data;
  logic        out2_valid;
  logic        out2_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];

  logic        obs_in_ready;
  logic        obs_v1, obs_v2;
  logic [31:0] obs_d1, obs_d2;

  always #5 clk = ~clk;

  stream_demux_2 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the queue model, advance the model.
  task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                       input logic r1, input logic r2, input logic rs);
    logic cap1, cap2, exp_rdy;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d;
    out1_ready = r1; out2_ready = r2; rst = rs;
    #2;
    cap1 = (D == 2) ? (q1.size() < 2) : (q1.size() == 0 || r1);
    cap2 = (D == 2) ? (q2.size() < 2) : (q2.size() == 0 || r2);
    exp_rdy = !rs && (s ? cap2 : cap1);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    check("out2_valid", {31'd0, out2_valid}, {31'd0, q2.size() != 0});
    if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
    if (q2.size() != 0) check("out2_data", out2_data, q2[0]);
    obs_in_ready = in_ready;
    obs_v1 = out1_valid; obs_d1 = out1_data;
    obs_v2 = out2_valid; obs_d2 = out2_data;
    if (rs) begin
      q1.delete();
      q2.delete();
    end else begin
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (q2.size() != 0 && r2) void'(q2.pop_front());
      if (v && exp_rdy) begin
        if (s) q2.push_back(d);
        else   q1.push_back(d);
      end
    end
  endtask

  initial begin
    int acc;
    int not_rdy;
    int got1, got2;

    // Let the DUT leave its power-up X state before any comparison.
    @(posedge clk);
    @(posedge clk);

    // Reset with in_valid held high.
    cycle(1, 0, 32'h1111_1111, 1, 1, 1);
    cycle(1, 0, 32'h1111_1111, 1, 1, 1);
    check("rst_in_ready", {31'd0, obs_in_ready}, 32'd0);
    check("rst_out1_data", obs_d1, 32'd0);
    check("rst_out2_data", obs_d2, 32'd0);
    check("rst_valids", {30'd0, obs_v1, obs_v2}, 32'd0);
    cycle(0, 0, 0, 1, 1, 0);
    check("post_rst_in_ready", {31'd0, obs_in_ready}, 32'd1);

    // Steering.
    cycle(1, 0, 32'hA5A5_0001, 1, 1, 0);
    cycle(1, 1, 32'h5A5A_0002, 1, 1, 0);
    check("steer_v1", {31'd0, obs_v1}, 32'd1);
    check("steer_d1", obs_d1, 32'hA5A5_0001);
    cycle(0, 0, 0, 1, 1, 0);
    check("steer_v1_once", {31'd0, obs_v1}, 32'd0);
    check("steer_v2", {31'd0, obs_v2}, 32'd1);
    check("steer_d2", obs_d2, 32'h5A5A_0002);
    cycle(0, 0, 0, 1, 1, 0);
    check("steer_v2_once", {31'd0, obs_v2}, 32'd0);

    // Backpressure isolation.
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 32'hB000_0000 + i, 0, 1, 0);
      if (obs_in_ready) acc++;
    end
    check("bp_accepted", acc, D);
    cycle(1, 1, 32'hC0DE_0003, 0, 1, 0);
    check("bp_other_rdy", {31'd0, obs_in_ready}, 32'd1);
    cycle(0, 0, 0, 0, 1, 0);
    check("bp_other_v2", {31'd0, obs_v2}, 32'd1);
    check("bp_other_d2", obs_d2, 32'hC0DE_0003);
    check("bp_hold_d1", obs_d1, 32'hB000_0000);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);

    // Streaming with alternating select.
    not_rdy = 0; got1 = 0; got2 = 0;
    for (int i = 0; i < 101; i++) begin
      if (i < 100) cycle(1, i[0], 32'h5000_0000 + i, 1, 1, 0);
      else         cycle(0, 0, 0, 1, 1, 0);
      if (i < 100 && !obs_in_ready) not_rdy++;
      if (obs_v1) got1++;
      if (obs_v2) got2++;
    end
    check("stream_not_ready", not_rdy, 0);
    check("stream_got1", got1, 50);
    check("stream_got2", got2, 50);

    // Full channel 2 with simultaneous pop and push.
    for (int i = 0; i < D; i++) cycle(1, 1, 32'hF000_0000 + i, 0, 0, 0);
    cycle(1, 1, 32'hF000_00AA, 0, 1, 0);
    check("full_pop_rdy", {31'd0, obs_in_ready}, {31'd0, D == 1});
    cycle(0, 0, 0, 0, 0, 0);
    check("full_pop_next", obs_d2, (D == 1) ? 32'hF000_00AA : 32'hF000_0001);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);

    // Reset mid-stream.
    cycle(1, 0, 32'hDEAD_0001, 0, 0, 0);
    cycle(1, 1, 32'hDEAD_0002, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1, 0);
    check("midrst_valids", {30'd0, obs_v1, obs_v2}, 32'd0);
    cycle(0, 0, 0, 1, 1, 0);
    check("midrst_none", {30'd0, obs_v1, obs_v2}, 32'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) != 0, $urandom % 2, $urandom,
            ($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 200) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
